pipe_reg_skid: RTL and testbench

- Parametrised successor of the backend stage register. Holds one payload per stage, driven by a valid/ready handshake instead of a global stall.
- Adds an optional 2-entry skid buffer, so in_ready is a registered signal and full throughput is kept across stage boundaries.
- Adds a selective redirect flush: only entries younger than the redirecting robid are killed. flush_all kills everything.
- Sits between any two backend stages, e.g. issue->exu or exu->wb. The payload is an opaque packed vector.

---
 rtl/backend_pkg.sv | 16 +
 rtl/robid_age_cmp.sv | 21 ++
 rtl/pipe_reg_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_reg_skid.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/backend_pkg.sv
// Shared backend types: the robid age tag and its wrap-aware age comparison.
package backend_pkg;

  localparam int ROBID_W = 7;

  typedef struct packed {
    logic              wrap;
    logic [ROBID_W-2:0] idx;
  } robid_t;

  // a is younger than b when it is ahead in allocation order, modulo one wrap.
  function automatic logic robid_is_younger(input robid_t a, input robid_t b);
    return (a.wrap ^ b.wrap) ^ (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/robid_age_cmp.sv
// Combinational age comparator: younger = a was allocated after b.
module robid_age_cmp
  import backend_pkg::*;
#(
  parameter int ROBID_WIDTH = 7
) (
  input  logic [ROBID_WIDTH-1:0] a,
  input  logic [ROBID_WIDTH-1:0] b,
  output logic                   younger
);

  generate
    if (ROBID_WIDTH == ROBID_W) begin : g_pkg
      assign younger = robid_is_younger(robid_t'(a), robid_t'(b));
    end else begin : g_generic
      assign younger = (a[ROBID_WIDTH-1] ^ b[ROBID_WIDTH-1]) ^
                       (a[ROBID_WIDTH-2:0] > b[ROBID_WIDTH-2:0]);
    end
  endgenerate

endmodule

// File: rtl/pipe_reg_skid.sv
// Valid/ready backend stage register with optional 2-entry skid buffer and
// age-selective redirect flush.
module pipe_reg_skid
  import backend_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ROBID_WIDTH = 7,
  parameter int SKID_EN     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [ROBID_WIDTH-1:0] in_robid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ROBID_WIDTH-1:0] out_robid,
  input  logic                   flush_valid,
  input  logic [ROBID_WIDTH-1:0] flush_robid,
  input  logic                   flush_all,
  output logic [1:0]             occupancy
);

  logic                   head_vld_p0;
  logic [DATA_WIDTH-1:0]  head_data_p0;
  logic [ROBID_WIDTH-1:0] head_robid_p0;
  logic                   skid_vld_p1;

  logic head_young;
  logic in_young;
  logic release_head;
  logic accept_in;
  logic kill_head;
  logic kill_in;
  logic store_in;

  robid_age_cmp #(.ROBID_WIDTH(ROBID_WIDTH)) u_cmp_head (
    .a       (head_robid_p0),
    .b       (flush_robid),
    .younger (head_young)
  );

  robid_age_cmp #(.ROBID_WIDTH(ROBID_WIDTH)) u_cmp_in (
    .a       (in_robid),
    .b       (flush_robid),
    .younger (in_young)
  );

  assign release_head = head_vld_p0 & out_ready;
  assign accept_in    = in_valid & in_ready;
  assign kill_head    = flush_all | (flush_valid & head_young);
  assign kill_in      = flush_all | (flush_valid & in_young);
  // A flushed incoming payload is consumed by the handshake but never stored.
  assign store_in     = accept_in & ~kill_in;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [DATA_WIDTH-1:0]  skid_data_p1;
      logic [ROBID_WIDTH-1:0] skid_robid_p1;
      logic                   skid_young;
      logic                   kill_skid;
      logic                   head_keep;
      logic                   skid_keep;

      robid_age_cmp #(.ROBID_WIDTH(ROBID_WIDTH)) u_cmp_skid (
        .a       (skid_robid_p1),
        .b       (flush_robid),
        .younger (skid_young)
      );

      // Skid is always younger than head, so a dead head takes the skid with it.
      assign kill_skid = kill_head | (flush_valid & skid_young);
      assign head_keep = head_vld_p0 & ~release_head & ~kill_head;
      assign skid_keep = skid_vld_p1 & ~kill_skid;
      assign in_ready  = ~skid_vld_p1;

      always_ff @(posedge clock) begin
        if (reset) begin
          head_vld_p0   <= 1'b0;
          head_data_p0  <= '0;
          head_robid_p0 <= '0;
          skid_vld_p1   <= 1'b0;
          skid_data_p1  <= '0;
          skid_robid_p1 <= '0;
        end else if (head_keep) begin
          if (!skid_keep && store_in) begin
            skid_vld_p1   <= 1'b1;
            skid_data_p1  <= in_data;
            skid_robid_p1 <= in_robid;
          end else begin
            skid_vld_p1   <= skid_keep;
          end
        end else if (skid_keep) begin
          head_vld_p0   <= 1'b1;
          head_data_p0  <= skid_data_p1;
          head_robid_p0 <= skid_robid_p1;
          skid_vld_p1   <= 1'b0;
        end else begin
          head_vld_p0 <= store_in;
          skid_vld_p1 <= 1'b0;
          if (store_in) begin
            head_data_p0  <= in_data;
            head_robid_p0 <= in_robid;
          end
        end
      end
    end else begin : g_single
      assign skid_vld_p1 = 1'b0;
      assign in_ready    = ~head_vld_p0 | out_ready;

      always_ff @(posedge clock) begin
        if (reset) begin
          head_vld_p0   <= 1'b0;
          head_data_p0  <= '0;
          head_robid_p0 <= '0;
        end else if (store_in) begin
          head_vld_p0   <= 1'b1;
          head_data_p0  <= in_data;
          head_robid_p0 <= in_robid;
        end else if (release_head || kill_head) begin
          head_vld_p0   <= 1'b0;
        end
      end
    end
  endgenerate

  // Output stage boundary: head entry drives the downstream side.
  assign out_valid = head_vld_p0;
  assign out_data  = head_data_p0;
  assign out_robid = head_robid_p0;
  assign occupancy = {1'b0, head_vld_p0} + {1'b0, skid_vld_p1};

  a_skid_implies_head: assert property (
    @(posedge clock) disable iff (reset) skid_vld_p1 |-> head_vld_p0);

  a_hold_stable: assert property (
    @(posedge clock) disable iff (reset)
    (out_valid & ~out_ready & ~flush_valid & ~flush_all) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: skid build plus a single-register build.
module tb_pipe_reg_skid;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic [6:0]  in_robid;
  logic        out_ready;
  logic        flush_valid;
  logic [6:0]  flush_robid;
  logic        flush_all;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [6:0]  out_robid;
  logic [1:0]  occupancy;

  logic        d0_in_ready, d0_out_valid;
  logic [63:0] d0_out_data;
  logic [6:0]  d0_out_robid;
  logic [1:0]  d0_occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_reg_skid #(.DATA_WIDTH(64), .ROBID_WIDTH(7), .SKID_EN(1)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_robid(in_robid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_robid(out_robid),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .flush_all(flush_all),
    .occupancy(occupancy)
  );

  pipe_reg_skid #(.DATA_WIDTH(64), .ROBID_WIDTH(7), .SKID_EN(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(d0_in_ready), .in_data(in_data), .in_robid(in_robid),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_data(d0_out_data), .out_robid(d0_out_robid),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .flush_all(flush_all),
    .occupancy(d0_occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [6:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_robid = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic ov, input logic [1:0] occ,
                             input logic ir);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_robid = '0;
    out_ready = 1'b0; flush_valid = 1'b0; flush_robid = '0; flush_all = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_state("reset", 1'b0, 2'd0, 1'b1);
    check("reset.out_data",  out_data, 64'h0);
    check("reset.out_robid", 64'(out_robid), 64'h0);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_robid = 7'(i);
      tick();
      check_state("stream", 1'b1, 2'd1, 1'b1);
      check("stream.out_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check_state("stream.drain", 1'b0, 2'd0, 1'b1);

    // Backpressure fills the skid
    out_ready = 1'b0;
    push(64'hA, 7'd1);
    check_state("bp.a", 1'b1, 2'd1, 1'b1);
    push(64'hB, 7'd2);
    check_state("bp.ab", 1'b1, 2'd2, 1'b0);
    check("bp.ab.data", out_data, 64'hA);
    push(64'hC, 7'd3);
    check_state("bp.ignored", 1'b1, 2'd2, 1'b0);
    check("bp.ignored.data", out_data, 64'hA);
    out_ready = 1'b1;
    tick();
    check_state("bp.rel_a", 1'b1, 2'd1, 1'b1);
    check("bp.rel_a.data", out_data, 64'hB);
    tick();
    check_state("bp.rel_b", 1'b0, 2'd0, 1'b1);

    // Selective flush
    out_ready = 1'b0;
    push(64'h55, 7'd5);
    push(64'h66, 7'd6);
    check_state("sel.full", 1'b1, 2'd2, 1'b0);
    flush_valid = 1'b1; flush_robid = 7'd5;
    tick();
    flush_valid = 1'b0;
    check_state("sel.f5", 1'b1, 2'd1, 1'b1);
    check("sel.f5.robid", 64'(out_robid), 64'd5);
    push(64'h66, 7'd6);
    check_state("sel.refill", 1'b1, 2'd2, 1'b0);
    flush_valid = 1'b1; flush_robid = 7'd4;
    tick();
    flush_valid = 1'b0;
    check_state("sel.f4", 1'b0, 2'd0, 1'b1);
    check("sel.f4.data_kept", out_data, 64'h55);

    // Wrap-around age compare
    push(64'h3F, 7'h3F);
    check_state("wrap.head", 1'b1, 2'd1, 1'b1);
    in_valid = 1'b1; in_data = 64'h40; in_robid = 7'h40;
    flush_valid = 1'b1; flush_robid = 7'h3F;
    tick();
    in_valid = 1'b0; flush_valid = 1'b0;
    check_state("wrap.drop", 1'b1, 2'd1, 1'b1);
    check("wrap.robid", 64'(out_robid), 64'h3F);
    check("wrap.data",  out_data, 64'h3F);
    out_ready = 1'b1;
    tick();
    check_state("wrap.drain", 1'b0, 2'd0, 1'b1);

    // flush_all while full, then with a single entry and an acceptable input
    out_ready = 1'b0;
    push(64'hA0, 7'd10);
    push(64'hB0, 7'd11);
    check_state("fa.full", 1'b1, 2'd2, 1'b0);
    flush_all = 1'b1; in_valid = 1'b1; in_data = 64'hC0; in_robid = 7'd12;
    tick();
    flush_all = 1'b0; in_valid = 1'b0;
    check_state("fa.cleared", 1'b0, 2'd0, 1'b1);
    tick();
    check_state("fa.nothing", 1'b0, 2'd0, 1'b1);
    push(64'hD0, 7'd13);
    flush_all = 1'b1; in_valid = 1'b1; in_data = 64'hE0; in_robid = 7'd14;
    tick();
    flush_all = 1'b0; in_valid = 1'b0;
    check_state("fa.single", 1'b0, 2'd0, 1'b1);
    tick();
    check_state("fa.single.after", 1'b0, 2'd0, 1'b1);

    // Reset while full with downstream ready
    push(64'h20, 7'd20);
    push(64'h21, 7'd21);
    check_state("rst.full", 1'b1, 2'd2, 1'b0);
    out_ready = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state("rst.mid", 1'b0, 2'd0, 1'b1);
    check("rst.mid.data",  out_data, 64'h0);
    check("rst.mid.robid", 64'(out_robid), 64'h0);
    tick();
    check_state("rst.after", 1'b0, 2'd0, 1'b1);

    // Single-register build: combinational in_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h31; in_robid = 7'd1;
    #1;
    check("s0.empty.in_ready", 64'(d0_in_ready), 64'd1);
    tick();
    check("s0.held.valid", 64'(d0_out_valid), 64'd1);
    check("s0.held.occ",   64'(d0_occupancy), 64'd1);
    check("s0.held.in_ready", 64'(d0_in_ready), 64'd0);
    check("s0.held.data",  d0_out_data, 64'h31);
    in_data = 64'h32; in_robid = 7'd2;
    tick();
    check("s0.stall.data", d0_out_data, 64'h31);
    check("s0.stall.in_ready", 64'(d0_in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("s0.follow.in_ready", 64'(d0_in_ready), 64'd1);
    tick();
    check("s0.pass.data", d0_out_data, 64'h32);
    check("s0.pass.robid", 64'(d0_out_robid), 64'd2);
    check("s0.pass.occ",  64'(d0_occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    check("s0.drain.valid", 64'(d0_out_valid), 64'd0);
    check("s0.drain.occ",   64'(d0_occupancy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
